bus_fabric: RTL



---
 rtl/bus_fabric_if.sv | 38 +++
 rtl/bus_fabric.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_fabric_if.sv
// bus_fabric_if: core data-port request/response plus the broadcast slave bus, bundled as one port.
// Latency: none, wires only.
// Backpressure: s_ready stalls completion, and the core holds m_ren/m_wen until m_ready.
// Ports: slave modport is the fabric. master modport is its environment: the requesting core
//        plus the responding peripherals.
interface bus_fabric_if #(
  parameter int N_SLAVES = 8,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
);
  // core side
  logic [ADDR_W-1:0]          m_addr;
  logic [DATA_W-1:0]          m_wdata;
  logic [DATA_W/8-1:0]        m_wstrb;
  logic                       m_ren;
  logic                       m_wen;
  logic [DATA_W-1:0]          m_rdata;
  logic                       m_ready;
  logic                       m_err;
  // peripheral side
  logic [ADDR_W-1:0]          s_addr;
  logic [DATA_W-1:0]          s_wdata;
  logic [DATA_W/8-1:0]        s_wstrb;
  logic [N_SLAVES-1:0]        s_ren;
  logic [N_SLAVES-1:0]        s_wen;
  logic [N_SLAVES*DATA_W-1:0] s_rdata;
  logic [N_SLAVES-1:0]        s_ready;

  modport slave (
    input  m_addr, m_wdata, m_wstrb, m_ren, m_wen, s_rdata, s_ready,
    output m_rdata, m_ready, m_err, s_addr, s_wdata, s_wstrb, s_ren, s_wen
  );

  modport master (
    output m_addr, m_wdata, m_wstrb, m_ren, m_wen, s_rdata, s_ready,
    input  m_rdata, m_ready, m_err, s_addr, s_wdata, s_wstrb, s_ren, s_wen
  );
endinterface

// File: rtl/bus_fabric.sv
// bus_fabric: decodes core requests onto N peripheral windows and an internal error-register pair.
// Latency: 2 cycles minimum (request -> registered strobe -> m_ready), +1 per slave wait state.
//          The issue interval is at least 3 cycles.
// Backpressure: a strobe is held until s_ready of the selected slave, or until TIMEOUT cycles have
//               passed. The core holds its request level until the m_ready pulse.
// Ports: clk, rst (synchronous, active-high); bus (slave modport); err_irq, the sticky error flag.
module bus_fabric #(
  parameter int                         N_SLAVES    = 8,
  parameter int                         ADDR_W      = 32,
  parameter int                         DATA_W      = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE    = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_SIZE    = '0,
  parameter int                         DEFAULT_SLV = 0,
  parameter int                         TIMEOUT     = 255,
  parameter logic [ADDR_W-1:0]          ERR_BASE    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  bus_fabric_if.slave bus,
  output logic        err_irq
);
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [1:0] TGT_SLV   = 2'd0;
  localparam logic [1:0] TGT_REG   = 2'd1;
  localparam logic [1:0] TGT_UNMAP = 2'd2;

  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] ERR_LO   = {1'b0, ERR_BASE};
  localparam logic [ADDR_W:0] ERR_HI   = ERR_LO + (ADDR_W+1)'(8);

  logic [1:0]       state;
  logic [1:0]       tgt_q;
  logic [SEL_W-1:0] sel_q;
  logic             wr_q;
  logic [15:0]      wait_cnt;

  logic [ADDR_W-1:0] err_addr;
  logic [1:0]        err_cause;
  logic [15:0]       err_count;

  // ---------------- decode ----------------
  // Window bounds are widened by one bit, so a window that ends at the top of the address space
  // does not wrap around.
  logic [ADDR_W:0]  addr_x;
  logic [ADDR_W:0]  win_lo;
  logic [ADDR_W:0]  win_hi;
  logic [1:0]       dec_tgt;
  logic [SEL_W-1:0] dec_sel;

  always_comb begin
    addr_x  = {1'b0, bus.m_addr};
    win_lo  = '0;
    win_hi  = '0;
    dec_tgt = TGT_UNMAP;
    dec_sel = '0;
    // Scanning downward lets the lowest matching index overwrite the others.
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      win_lo = {1'b0, SLV_BASE[i*ADDR_W +: ADDR_W]};
      win_hi = win_lo + {1'b0, SLV_SIZE[i*ADDR_W +: ADDR_W]};
      if (SLV_SIZE[i*ADDR_W +: ADDR_W] != '0 && addr_x >= win_lo && addr_x < win_hi) begin
        dec_tgt = TGT_SLV;
        dec_sel = SEL_W'(i);
      end
    end
    if (dec_tgt == TGT_UNMAP && DEFAULT_SLV < N_SLAVES) begin
      dec_tgt = TGT_SLV;
      dec_sel = SEL_W'(DEFAULT_SLV);
    end
    // The error registers shadow any slave window that overlaps them.
    if (addr_x >= ERR_LO && addr_x < ERR_HI) dec_tgt = TGT_REG;
  end

  // ---------------- access-phase helpers ----------------
  logic              sel_ready;
  logic              reg_hi;     // selects ERR_BASE+4 (status) rather than ERR_BASE+0
  logic [31:0]       status_word;
  logic              err_evt;
  logic              err_clr;
  logic [1:0]        err_evt_cause;

  assign sel_ready   = bus.s_ready[sel_q];
  assign reg_hi      = (bus.s_addr - ERR_BASE) >= ADDR_W'(4);
  assign status_word = {err_cause, 14'b0, err_count};

  always_comb begin
    err_evt       = 1'b0;
    err_clr       = 1'b0;
    err_evt_cause = CAUSE_UNMAPPED;
    if (state == ACCESS) begin
      case (tgt_q)
        TGT_SLV: begin
          if (!sel_ready && wait_cnt == TMO_LAST) begin
            err_evt       = 1'b1;
            err_evt_cause = CAUSE_TIMEOUT;
          end
        end
        TGT_REG: err_clr = wr_q && reg_hi;
        default: err_evt = 1'b1;
      endcase
    end
  end

  // ---------------- transfer FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tgt_q       <= TGT_SLV;
      sel_q       <= '0;
      wr_q        <= 1'b0;
      wait_cnt    <= '0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.s_wstrb <= '0;
      bus.s_ren   <= '0;
      bus.s_wen   <= '0;
      bus.m_rdata <= '0;
      bus.m_ready <= 1'b0;
      bus.m_err   <= 1'b0;
    end else begin
      bus.m_ready <= 1'b0;
      case (state)
        IDLE: begin
          bus.m_err <= 1'b0;
          if (bus.m_ren || bus.m_wen) begin
            bus.s_addr  <= bus.m_addr;
            bus.s_wdata <= bus.m_wdata;
            bus.s_wstrb <= bus.m_wstrb;
            wr_q        <= bus.m_wen;
            tgt_q       <= dec_tgt;
            sel_q       <= dec_sel;
            wait_cnt    <= '0;
            if (dec_tgt == TGT_SLV) begin
              if (bus.m_wen) bus.s_wen <= N_SLAVES'(1) << dec_sel;
              else           bus.s_ren <= N_SLAVES'(1) << dec_sel;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          case (tgt_q)
            TGT_SLV: begin
              wait_cnt <= wait_cnt + 16'd1;
              // Completion takes priority over a timeout in the same cycle.
              if (sel_ready) begin
                bus.s_ren   <= '0;
                bus.s_wen   <= '0;
                bus.m_rdata <= bus.s_rdata[int'(sel_q)*DATA_W +: DATA_W];
                bus.m_err   <= 1'b0;
                bus.m_ready <= 1'b1;
                state       <= RESP;
              end else if (wait_cnt == TMO_LAST) begin
                bus.s_ren   <= '0;
                bus.s_wen   <= '0;
                bus.m_err   <= 1'b1;
                bus.m_ready <= 1'b1;
                state       <= RESP;
              end
            end
            TGT_REG: begin
              if (!wr_q) bus.m_rdata <= reg_hi ? DATA_W'(status_word) : DATA_W'(err_addr);
              bus.m_err   <= 1'b0;
              bus.m_ready <= 1'b1;
              state       <= RESP;
            end
            default: begin
              bus.m_err   <= 1'b1;
              bus.m_ready <= 1'b1;
              state       <= RESP;
            end
          endcase
        end
        default: begin
          // RESP: the request is not sampled again until the FSM is back in IDLE.
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------- error capture ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr  <= '0;
      err_cause <= '0;
      err_count <= '0;
      err_irq   <= 1'b0;
    end else begin
      if (err_clr) begin
        err_cause <= '0;
        err_count <= '0;
        err_irq   <= 1'b0;
      end
      // Ordered after the clear, so a coincident error survives it.
      if (err_evt) begin
        err_addr  <= bus.s_addr;
        err_cause <= err_evt_cause;
        err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
        err_irq   <= 1'b1;
      end
    end
  end
endmodule
